// File: rtl/systolic_scheduler.sv
// Sequencer for an LxL FP16 systolic array: buffers operand rows, feeds them as a skewed
// wavefront, waits for the array result and returns it over a valid/ready handshake.
module systolic_scheduler #(
    parameter int unsigned L       = 4,
    parameter int unsigned W       = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [L*W-1:0]   in_row,
    input  logic [L*W-1:0]   b_vec,
    output logic             sa_reset,
    output logic             sa_en,
    output logic [L*W-1:0]   sa_a,
    output logic [L*W-1:0]   sa_b,
    input  logic [L*W-1:0]   sa_p,
    input  logic             sa_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [L*W-1:0]   out_vec,
    output logic             err
);

    localparam int unsigned LW = L * W;
    localparam int unsigned RW = (L > 1) ? $clog2(L) : 1;
    localparam int unsigned TW = $clog2(2 * L - 1);
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_LOAD,
        S_FEED,
        S_DRAIN,
        S_OUT
    } state_e;

    state_e                  state_q, state_d;
    logic [RW-1:0]           r_q, r_d;
    logic [TW-1:0]           t_q, t_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [L-1:0][LW-1:0]    buf_q, buf_d;
    logic [LW-1:0]           sa_a_q, sa_a_d;
    logic [LW-1:0]           sa_b_q, sa_b_d;
    logic [LW-1:0]           out_vec_q, out_vec_d;
    logic                    busy_q, busy_d;
    logic                    in_ready_q, in_ready_d;
    logic                    sa_reset_q, sa_reset_d;
    logic                    sa_en_q, sa_en_d;
    logic                    out_valid_q, out_valid_d;
    logic                    err_q, err_d;
    int                      diff;

    // Next state; outputs are decoded from the next state so they line up with state_q.
    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        t_d       = t_q;
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        sa_b_d    = sa_b_q;
        out_vec_d = out_vec_q;
        err_d     = err_q;
        sa_a_d    = '0;
        diff      = 0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sa_b_d  = b_vec;
                    err_d   = 1'b0;
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                r_d     = '0;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                if (in_valid) begin
                    buf_d[r_q] = in_row;
                    r_d        = r_q + RW'(1);
                    if (r_q == RW'(L - 1)) begin
                        t_d     = '0;
                        state_d = S_FEED;
                    end
                end
            end
            S_FEED: begin
                if (t_q == TW'(2 * L - 2)) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    t_d = t_q + TW'(1);
                end
            end
            S_DRAIN: begin
                if (sa_ready) begin
                    out_vec_d = sa_p;
                    state_d   = S_OUT;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d      = (state_d != S_IDLE);
        in_ready_d  = (state_d == S_LOAD);
        sa_reset_d  = (state_d == S_CLR);
        sa_en_d     = (state_d == S_FEED) || (state_d == S_DRAIN);
        out_valid_d = (state_d == S_OUT);

        // Lane i carries A[t-i][i], giving the diagonal wavefront.
        if (state_d == S_FEED) begin
            for (int unsigned i = 0; i < L; i++) begin
                diff = int'(t_d) - int'(i);
                if (diff >= 0 && diff < int'(L)) begin
                    sa_a_d[i*W +: W] = buf_q[RW'(diff)][i*W +: W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            r_q         <= '0;
            t_q         <= '0;
            cnt_q       <= '0;
            buf_q       <= '0;
            sa_a_q      <= '0;
            sa_b_q      <= '0;
            out_vec_q   <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            sa_reset_q  <= 1'b0;
            sa_en_q     <= 1'b0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            t_q         <= t_d;
            cnt_q       <= cnt_d;
            buf_q       <= buf_d;
            sa_a_q      <= sa_a_d;
            sa_b_q      <= sa_b_d;
            out_vec_q   <= out_vec_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
            sa_reset_q  <= sa_reset_d;
            sa_en_q     <= sa_en_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    assign busy      = busy_q;
    assign in_ready  = in_ready_q;
    assign sa_reset  = sa_reset_q;
    assign sa_en     = sa_en_q;
    assign sa_a      = sa_a_q;
    assign sa_b      = sa_b_q;
    assign out_valid = out_valid_q;
    assign out_vec   = out_vec_q;
    assign err       = err_q;

endmodule

// File: tb/tb_systolic_scheduler.sv
// Directed bench for systolic_scheduler: skew tables for two operand matrices plus
// hand-written load-stall, handshake, timeout and abort sequences.
module tb_systolic_scheduler;

    localparam int unsigned L       = 4;
    localparam int unsigned W       = 16;
    localparam int unsigned TIMEOUT = 64;
    localparam int unsigned LW      = L * W;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          busy;
    logic          in_valid;
    logic          in_ready;
    logic [LW-1:0] in_row;
    logic [LW-1:0] b_vec;
    logic          sa_reset;
    logic          sa_en;
    logic [LW-1:0] sa_a;
    logic [LW-1:0] sa_b;
    logic [LW-1:0] sa_p;
    logic          sa_ready;
    logic          out_valid;
    logic          out_ready;
    logic [LW-1:0] out_vec;
    logic          err;

    systolic_scheduler #(.L(L), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_row    (in_row),
        .b_vec     (b_vec),
        .sa_reset  (sa_reset),
        .sa_en     (sa_en),
        .sa_a      (sa_a),
        .sa_b      (sa_b),
        .sa_p      (sa_p),
        .sa_ready  (sa_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_vec   (out_vec),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          start_in;
        logic [LW-1:0] exp_a;
    } feed_vec_t;

    feed_vec_t ident_tab[7];
    feed_vec_t ramp_tab[7];

    int checks = 0;
    int passed = 0;

    localparam logic [LW-1:0] B1     = {16'h4C00, 16'h4400, 16'h4000, 16'h3C00};
    localparam logic [LW-1:0] B2     = {16'h5000, 16'h4E00, 16'h4A00, 16'h4200};
    localparam logic [LW-1:0] P4400  = {4{16'h4400}};
    localparam logic [LW-1:0] JUNK   = {4{16'hDEAD}};

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LW-1:0] ident_row(input int r);
        logic [LW-1:0] v;
        v = '0;
        v[r*W +: W] = 16'h3C00;
        return v;
    endfunction

    function automatic logic [LW-1:0] ramp_row(input int r);
        logic [LW-1:0] v;
        for (int c = 0; c < int'(L); c++) v[c*W +: W] = W'(16'h1000 * (r + 1) + c);
        return v;
    endfunction

    // Accept start in IDLE and check the single CLR cycle; ends observing the first LOAD cycle.
    task automatic begin_op(input logic [LW-1:0] b);
        start = 1'b1;
        b_vec = b;
        step();
        start = 1'b0;
        b_vec = '1;
        chk1("clr_sa_reset", sa_reset, 1'b1);
        chk1("clr_sa_en", sa_en, 1'b0);
        chk1("clr_busy", busy, 1'b1);
        chk1("clr_err", err, 1'b0);
        chk("clr_sa_a", sa_a, '0);
        chk("clr_sa_b", sa_b, b);
        step();
    endtask

    // Drive in_valid per pattern bit k on the k-th LOAD cycle; ends observing FEED t=0.
    task automatic load_rows(input bit ramp, input logic [6:0] pat, input int n);
        int r;
        r = 0;
        for (int k = 0; k < n; k++) begin
            chk1("load_in_ready", in_ready, 1'b1);
            in_valid = pat[k];
            if (pat[k]) begin
                in_row = ramp ? ramp_row(r) : ident_row(r);
                r++;
            end else begin
                in_row = JUNK;
            end
            step();
        end
        in_valid = 1'b0;
        in_row   = JUNK;
        chk1("feed_entry_in_ready", in_ready, 1'b0);
    endtask

    // Walk the seven FEED steps against a table; ends observing DRAIN cycle 0.
    task automatic run_feed(input bit ramp, input logic [LW-1:0] b);
        feed_vec_t e;
        for (int k = 0; k < 7; k++) begin
            e = ramp ? ramp_tab[k] : ident_tab[k];
            chk("feed_sa_a", sa_a, e.exp_a);
            chk1("feed_sa_en", sa_en, 1'b1);
            chk("feed_sa_b", sa_b, b);
            start = e.start_in;
            b_vec = e.start_in ? B1 ^ B2 : '1;
            step();
            start = 1'b0;
        end
        chk1("drain0_sa_en", sa_en, 1'b1);
        chk("drain0_sa_a", sa_a, '0);
        chk1("drain0_busy", busy, 1'b1);
    endtask

    initial begin
        ident_tab[0] = '{1'b0, 64'h0000_0000_0000_3C00};
        ident_tab[1] = '{1'b0, 64'h0000_0000_0000_0000};
        ident_tab[2] = '{1'b0, 64'h0000_0000_3C00_0000};
        ident_tab[3] = '{1'b0, 64'h0000_0000_0000_0000};
        ident_tab[4] = '{1'b0, 64'h0000_3C00_0000_0000};
        ident_tab[5] = '{1'b0, 64'h0000_0000_0000_0000};
        ident_tab[6] = '{1'b0, 64'h3C00_0000_0000_0000};
        ramp_tab[0]  = '{1'b0, 64'h0000_0000_0000_1000};
        ramp_tab[1]  = '{1'b0, 64'h0000_0000_1001_2000};
        ramp_tab[2]  = '{1'b1, 64'h0000_1002_2001_3000};
        ramp_tab[3]  = '{1'b0, 64'h1003_2002_3001_4000};
        ramp_tab[4]  = '{1'b0, 64'h2003_3002_4001_0000};
        ramp_tab[5]  = '{1'b0, 64'h3003_4002_0000_0000};
        ramp_tab[6]  = '{1'b0, 64'h4003_0000_0000_0000};

        reset     = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_row    = '0;
        b_vec     = '0;
        sa_p      = '0;
        sa_ready  = 1'b0;
        out_ready = 1'b0;

        // Reset values
        step();
        step();
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_in_ready", in_ready, 1'b0);
        chk1("rst_sa_en", sa_en, 1'b0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk("rst_sa_a", sa_a, '0);
        chk("rst_sa_b", sa_b, '0);
        chk("rst_out_vec", out_vec, '0);
        reset = 1'b1;
        step();
        chk1("idle_busy", busy, 1'b0);

        // Identity skew, then result handshake with sa_ready at DRAIN cycle 3
        begin_op(B1);
        load_rows(1'b0, 7'b0001111, 4);
        run_feed(1'b0, B1);
        step();
        step();
        chk1("drain2_out_valid", out_valid, 1'b0);
        step();
        chk1("drain3_busy", busy, 1'b1);
        sa_ready = 1'b1;
        sa_p     = P4400;
        step();
        sa_ready = 1'b0;
        sa_p     = JUNK;
        chk1("out_valid", out_valid, 1'b1);
        chk("out_vec", out_vec, P4400);
        chk1("out_sa_en", sa_en, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk1("out_hold_valid", out_valid, 1'b1);
            chk("out_hold_vec", out_vec, P4400);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk1("out_done_valid", out_valid, 1'b0);
        chk1("out_done_busy", busy, 1'b0);

        // Load stalls with ramp matrix, start pulsed in FEED, then DRAIN timeout
        begin_op(B2);
        load_rows(1'b1, 7'b1011001, 7);
        run_feed(1'b1, B2);
        for (int k = 0; k < int'(TIMEOUT) - 1; k++) step();
        chk1("drain_last_busy", busy, 1'b1);
        chk1("drain_last_err", err, 1'b0);
        step();
        chk1("timeout_err", err, 1'b1);
        chk1("timeout_busy", busy, 1'b0);
        chk1("timeout_out_valid", out_valid, 1'b0);
        chk("timeout_out_vec", out_vec, P4400);
        step();
        chk1("err_sticky", err, 1'b1);

        // Next start clears err; reset during DRAIN aborts everything
        begin_op(B1);
        load_rows(1'b0, 7'b0001111, 4);
        run_feed(1'b0, B1);
        step();
        reset = 1'b0;
        #1;
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_sa_en", sa_en, 1'b0);
        chk1("abort_err", err, 1'b0);
        chk1("abort_out_valid", out_valid, 1'b0);
        chk("abort_sa_a", sa_a, '0);
        chk("abort_sa_b", sa_b, '0);
        chk("abort_out_vec", out_vec, '0);
        step();
        reset = 1'b1;
        step();
        chk1("post_abort_idle", busy, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
